// File: rtl/updown_prescaled_counter.sv
// Prescaled up/down counter: modulo limit, wrap/saturate, load, clear, terminal-count pulse, compare flag.
// Defining COUNTER_CAPTURE_EN adds a count snapshot register behind cap_val.
module updown_prescaled_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             capture,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             cmp_match,
  output logic [WIDTH-1:0] cap_val
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_term;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = en;
    end else begin : g_prescale
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] p_q, p_d;

      assign tick = en && (p_q == P_LAST);

      // Load does not disturb the prescaler phase; only clear and reset do.
      always_comb begin
        p_d = p_q;
        if (clear) begin
          p_d = '0;
        end else if (en) begin
          p_d = tick ? '0 : p_q + PW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_q <= '0;
        end else begin
          p_q <= p_d;
        end
      end
    end
  endgenerate

  assign at_term = up ? (count_q == MAX_C) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (tick) begin
      // tc fires on any step from the terminal value, including a blocked saturating step.
      tc_d = at_term;
      if (up) begin
        count_d = at_term ? (sat_mode ? MAX_C : '0) : count_q + WIDTH'(1);
      end else begin
        count_d = at_term ? (sat_mode ? '0 : MAX_C) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign cmp_match = (count_q == cmp_val);

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (capture) begin
      cap_q <= count_q;
    end
  end

  assign cap_val = cap_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_val        = '0;
`endif

endmodule

// File: tb/tb_updown_prescaled_counter.sv
// Randomised and directed bench for updown_prescaled_counter: three instances with different
// MAX_VAL/PRESCALE share stimulus and are checked against a plain-arithmetic reference model.
module tb_updown_prescaled_counter;

  logic       clk;
  logic       rst_n;
  logic       en, up, clear, load, sat_mode, capture;
  logic [7:0] load_val, cmp_val;

  logic [7:0] count_w [3];
  logic       tick_w  [3];
  logic       tc_w    [3];
  logic       cmp_w   [3];
  logic [7:0] cap_w   [3];

  int MAXV [3] = '{255, 9, 99};
  int PSV  [3] = '{1, 1, 4};

  int m_count [3];
  int m_p     [3];
  int m_tc    [3];
  int m_cap   [3];

  int checks = 0;
  int passes = 0;

  updown_prescaled_counter #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .cmp_val(cmp_val), .capture(capture),
    .count(count_w[0]), .tick(tick_w[0]), .tc(tc_w[0]), .cmp_match(cmp_w[0]), .cap_val(cap_w[0]));

  updown_prescaled_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .cmp_val(cmp_val), .capture(capture),
    .count(count_w[1]), .tick(tick_w[1]), .tc(tc_w[1]), .cmp_match(cmp_w[1]), .cap_val(cap_w[1]));

  updown_prescaled_counter #(.WIDTH(8), .MAX_VAL(99), .PRESCALE(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .cmp_val(cmp_val), .capture(capture),
    .count(count_w[2]), .tick(tick_w[2]), .tc(tc_w[2]), .cmp_match(cmp_w[2]), .cap_val(cap_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit model_tick(int i);
    return en && (m_p[i] == PSV[i] - 1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0;
      m_p[i]     = 0;
      m_tc[i]    = 0;
      m_cap[i]   = 0;
    end
  endfunction

  // One clock of the behaviour, from the current inputs and model state.
  function automatic void model_update();
    for (int i = 0; i < 3; i++) begin
      bit tk;
      tk = model_tick(i);
`ifdef COUNTER_CAPTURE_EN
      if (capture) m_cap[i] = m_count[i];
`endif
      if (clear) begin
        m_count[i] = 0;
        m_p[i]     = 0;
        m_tc[i]    = 0;
      end else begin
        if (en) m_p[i] = tk ? 0 : m_p[i] + 1;
        if (load) begin
          m_count[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
          m_tc[i]    = 0;
        end else if (tk) begin
          if (up) begin
            m_tc[i]    = (m_count[i] == MAXV[i]) ? 1 : 0;
            m_count[i] = (m_count[i] < MAXV[i]) ? m_count[i] + 1 : (sat_mode ? MAXV[i] : 0);
          end else begin
            m_tc[i]    = (m_count[i] == 0) ? 1 : 0;
            m_count[i] = (m_count[i] > 0) ? m_count[i] - 1 : (sat_mode ? 0 : MAXV[i]);
          end
        end else begin
          m_tc[i] = 0;
        end
      end
    end
  endfunction

  task automatic run_cycle();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    run_cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    cmp_val = 8'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count_w[i] !== 8'd0 || tc_w[i] !== 1'b0 || cap_w[i] !== 8'd0 ||
          cmp_w[i] !== 1'b1 || tick_w[i] !== 1'b0)
        $display("FAIL reset inst=%0d got count=%0d tc=%b cap=%0d cmp=%b tick=%b exp 0,0,0,1,0",
                 i, count_w[i], tc_w[i], cap_w[i], cmp_w[i], tick_w[i]);
      else passes++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    en = 1'b1; up = 1'b1; sat_mode = 1'b0;
    for (int k = 0; k <= 257; k++) begin
      #1;
      checks++;
      if (count_w[0] !== 8'(k % 256) || tc_w[0] !== (k == 256))
        $display("FAIL wrap k=%0d got count=%0d tc=%b exp count=%0d tc=%b",
                 k, count_w[0], tc_w[0], k % 256, (k == 256));
      else passes++;
      run_cycle();
    end
    en = 1'b0;
  endtask

  task automatic test_saturate_down();
    int exp_cnt [7] = '{3, 2, 1, 0, 0, 0, 0};
    int exp_tc  [7] = '{0, 0, 0, 0, 1, 1, 1};
    do_clear();
    load = 1'b1; load_val = 8'd3;
    run_cycle();
    load = 1'b0;
    en = 1'b1; up = 1'b0; sat_mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      checks++;
      if (count_w[1] !== 8'(exp_cnt[k]) || tc_w[1] !== 1'(exp_tc[k]))
        $display("FAIL sat_down k=%0d got count=%0d tc=%b exp count=%0d tc=%0d",
                 k, count_w[1], tc_w[1], exp_cnt[k], exp_tc[k]);
      else passes++;
      run_cycle();
    end
    en = 1'b0; sat_mode = 1'b0;
  endtask

  task automatic test_prescale();
    do_clear();
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (tick_w[2] !== (k % 4 == 3) || count_w[2] !== 8'(k / 4))
        $display("FAIL prescale k=%0d got tick=%b count=%0d exp tick=%b count=%0d",
                 k, tick_w[2], count_w[2], (k % 4 == 3), k / 4);
      else passes++;
      run_cycle();
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (tick_w[2] !== 1'b0 || count_w[2] !== 8'd3)
        $display("FAIL prescale_hold k=%0d got tick=%b count=%0d exp tick=0 count=3",
                 k, tick_w[2], count_w[2]);
      else passes++;
      run_cycle();
    end
    en = 1'b1;
    repeat (4) run_cycle();
    #1;
    checks++;
    if (count_w[2] !== 8'd4)
      $display("FAIL prescale_resume got count=%0d exp 4", count_w[2]);
    else passes++;
    en = 1'b0;
  endtask

  task automatic test_priority();
    do_clear();
    en = 1'b1; up = 1'b1;
    repeat (3) run_cycle();
    clear = 1'b1; load = 1'b1; load_val = 8'd50;
    #1;
    checks++;
    if (tick_w[2] !== 1'b1)
      $display("FAIL prio_tick got %b exp 1", tick_w[2]);
    else passes++;
    run_cycle();
    clear = 1'b0; en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count_w[i] !== 8'd0 || tc_w[i] !== 1'b0)
        $display("FAIL prio_clear inst=%0d got count=%0d tc=%b exp 0,0", i, count_w[i], tc_w[i]);
      else passes++;
    end
    load_val = 8'd200;
    run_cycle();
    load = 1'b0;
    #1;
    checks++;
    if (count_w[0] !== 8'd200 || count_w[1] !== 8'd9 || count_w[2] !== 8'd99)
      $display("FAIL load_clamp got %0d/%0d/%0d exp 200/9/99", count_w[0], count_w[1], count_w[2]);
    else passes++;
  endtask

  task automatic test_cmp_and_async_reset();
    cmp_val = 8'd5;
    do_clear();
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (cmp_w[0] !== (k == 5) || count_w[0] !== 8'(k))
        $display("FAIL cmp k=%0d got match=%b count=%0d exp match=%b count=%0d",
                 k, cmp_w[0], count_w[0], (k == 5), k);
      else passes++;
      if (k < 7) run_cycle();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count_w[i] !== 8'd0 || tc_w[i] !== 1'b0)
        $display("FAIL async_reset inst=%0d got count=%0d tc=%b exp 0,0", i, count_w[i], tc_w[i]);
      else passes++;
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle();
    #1;
    checks++;
    if (count_w[0] !== 8'd0 || tc_w[0] !== 1'b0)
      $display("FAIL post_reset got count=%0d tc=%b exp 0,0", count_w[0], tc_w[0]);
    else passes++;
  endtask

  task automatic test_capture();
    int exp_cap;
`ifdef COUNTER_CAPTURE_EN
    exp_cap = 42;
`else
    exp_cap = 0;
`endif
    load = 1'b1; load_val = 8'd42;
    run_cycle();
    load = 1'b0;
    capture = 1'b1; en = 1'b1; up = 1'b1;
    run_cycle();
    capture = 1'b0; en = 1'b0;
    #1;
    checks++;
    if (cap_w[0] !== 8'(exp_cap) || count_w[0] !== 8'd43)
      $display("FAIL capture got cap=%0d count=%0d exp cap=%0d count=43", cap_w[0], count_w[0], exp_cap);
    else passes++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      clear    = ($urandom_range(15) == 0);
      load     = ($urandom_range(9) == 0);
      en       = ($urandom_range(3) != 0);
      up       = ($urandom_range(3) != 0);
      sat_mode = $urandom_range(1);
      capture  = ($urandom_range(7) == 0);
      load_val = 8'($urandom_range(255));
      cmp_val  = 8'($urandom_range(15));
      #1;
      for (int i = 0; i < 3; i++) begin
        bit exp_tick, exp_cmp;
        exp_tick = model_tick(i);
        exp_cmp  = (m_count[i] == int'(cmp_val));
        checks++;
        if (count_w[i] !== 8'(m_count[i]) || tc_w[i] !== 1'(m_tc[i]) || tick_w[i] !== exp_tick ||
            cmp_w[i] !== exp_cmp || cap_w[i] !== 8'(m_cap[i]))
          $display("FAIL random k=%0d inst=%0d got cnt=%0d tc=%b tick=%b cmp=%b cap=%0d exp cnt=%0d tc=%0d tick=%b cmp=%b cap=%0d",
                   k, i, count_w[i], tc_w[i], tick_w[i], cmp_w[i], cap_w[i],
                   m_count[i], m_tc[i], exp_tick, exp_cmp, m_cap[i]);
        else passes++;
      end
      run_cycle();
    end
    clear = 1'b0; load = 1'b0; en = 1'b0; capture = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; sat_mode = 1'b0; capture = 1'b0;
    load_val = 8'd0; cmp_val = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_wrap();
    test_saturate_down();
    test_prescale();
    test_priority();
    test_cmp_and_async_reset();
    test_capture();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/updown_prescaled_counter.md
Name: updown_prescaled_counter

Overview:
Parametrised synchronous up/down counter, the successor to the combinational adder top-level.
- Programmable prescaler, modulo limit, wrap/saturate mode, parallel load, sync clear.
- Terminal-count pulse and compare-match flag.
- Instantiated inside the tt_um_* wrapper: ui_in/uio_in drive control and data, uo_out shows count.

Parameters:
WIDTH, 8, counter/data width in bits (2..16)
MAX_VAL, 2**WIDTH-1, inclusive upper count limit (modulo = MAX_VAL+1); must be >= 1
PRESCALE, 1, enabled clock cycles per count step (1 = every enabled cycle); must be >= 1

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
en  input  1  count enable; also gates the prescaler
up  input  1  direction: 1 = increment, 0 = decrement
clear  input  1  synchronous clear, highest priority
load  input  1  synchronous parallel load
load_val  input  WIDTH  value loaded when load=1
sat_mode  input  1  1 = saturate at bounds, 0 = wrap
cmp_val  input  WIDTH  compare value
capture  input  1  snapshot strobe (used only with COUNTER_CAPTURE_EN)
count  output  WIDTH  current count register
tick  output  1  prescaler tick; high in cycles where a step is taken
tc  output  1  registered one-cycle terminal-count pulse
cmp_match  output  1  count == cmp_val, combinational from count
cap_val  output  WIDTH  captured count

Behaviour:
- Reset (rst_n low, async): count=0, prescaler=0, tc=0, cap_val=0. tick and cmp_match follow from state (cmp_match=1 iff cmp_val==0).
- Prescaler: internal counter p in 0..PRESCALE-1.
  - Increments when en=1; holds when en=0.
  - tick = en && (p == PRESCALE-1); p returns to 0 on tick.
  - PRESCALE=1: tick = en.
- Priority per cycle: clear > load > step.
- clear=1: count<=0, p<=0, tc<=0. load/en ignored that cycle.
- load=1 (clear=0): count<=min(load_val, MAX_VAL). p is unaffected and keeps counting if en=1. No step that cycle. tc<=0.
- Step (tick=1, no clear/load):
  - up=1, count<MAX_VAL: count+1.
  - up=1, count==MAX_VAL: wrap to 0 (sat_mode=0) or hold MAX_VAL (sat_mode=1).
  - up=0, count>0: count-1.
  - up=0, count==0: wrap to MAX_VAL (sat_mode=0) or hold 0 (sat_mode=1).
- tc: registered. tc<=1 in the cycle after a step taken while count was at the terminal value (MAX_VAL when up, 0 when down), else 0.
  - Asserts in both wrap and saturate mode, so a saturated counter pulses tc on every blocked step.
- Count changes only on the clock after tick; latency from tick to new count = 1 cycle.
- Direction or sat_mode changes take effect on the next step; no pipeline.
- All arithmetic is WIDTH bits unsigned; no intermediate value exceeds MAX_VAL.
- rst_n deassertion mid-operation: counting resumes from 0 with p=0; no spurious tc.

Optional Feature:
COUNTER_CAPTURE_EN
- Defined: when capture=1, cap_val <= count (pre-update value of that cycle). Capture is independent of clear/load/step priority. cap_val holds otherwise.
- Undefined: cap_val tied to 0, capture ignored, no capture register synthesised. Ports remain so the wrapper is unchanged.

Test Plan:
- WIDTH=8, PRESCALE=1, en=1, up=1, sat_mode=0, from reset for 256 cycles -> count 0..255 then 0; tc high exactly one cycle, the cycle after the 255->0 step.
- MAX_VAL=9, up=0, sat_mode=1, load_val=3 then en=1 for 6 cycles -> count 3,2,1,0,0,0; tc pulses after each of the 2 blocked steps at 0.
- PRESCALE=4, en=1 for 12 cycles, then en=0 for 3 cycles, then en=1 -> tick every 4th enabled cycle; count=3 after 12 cycles; holds during en=0; p resumes without reset.
- Same cycle: clear=1, load=1, tick=1 -> count=0, tc=0. Then load=1 with load_val=200, MAX_VAL=99 -> count=99.
- cmp_val=5, count up from 0 -> cmp_match high only while count==5. Assert rst_n low mid-count at count=7 -> count=0 immediately (async), tc=0.
- With COUNTER_CAPTURE_EN: capture=1 while count=42 and a step is taken -> cap_val=42, count=43. Without it -> cap_val stays 0.
